// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: instruction kinds, FSM states
// and the padding word.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        KIND_R       = 2'b00,
        KIND_I       = 2'b01,
        KIND_J       = 2'b10,
        KIND_ILLEGAL = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_PAD  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns an instruction kind plus its fields into a
// 32-bit MIPS-style word, flagging the reserved kind as illegal.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [5:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // R-type always carries a zero opcode, so op is deliberately not used there.
    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        case (kind_e'(kind))
            KIND_R:  word = {6'b0, rs, rt, rd, shamt, funct};
            KIND_I:  word = {op, rs, rt, imm};
            KIND_J:  word = {op, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts instruction beats, writes encoded words to an
// instruction memory, then pads the image with NOPs.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int PAD_NOPS = 4
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        last_i,
    input  logic [1:0]  kind_i,
    input  logic [5:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [15:0] count_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    state_e      state;
    logic [31:0] addr;
    logic [15:0] pad_cnt;
    logic [31:0] packed_word;
    logic        illegal;
    logic        accept;
    logic        full_hit;
    logic        pad_room;
    logic        pad_final;

    instr_pack u_pack (
        .kind    (kind_i),
        .op      (op_i),
        .rs      (rs_i),
        .rt      (rt_i),
        .rd      (rd_i),
        .shamt   (shamt_i),
        .funct   (funct_i),
        .imm     (imm_i),
        .target  (target_i),
        .word    (packed_word),
        .illegal (illegal)
    );

    assign ready_o   = (state == ST_LOAD) && (addr < ADDR_LIMIT);
    assign accept    = valid_i && ready_o;
    assign full_hit  = (state == ST_LOAD) && valid_i && (addr >= ADDR_LIMIT);
    assign pad_room  = addr < ADDR_LIMIT;
    assign pad_final = (32'(pad_cnt) + 32'd1 >= 32'(PAD_NOPS)) ||
                       (addr + 32'd4 >= ADDR_LIMIT);

    // Single FSM: the write port is a one-cycle registered strobe, and addr
    // always holds the next free byte address, so it never passes ADDR_LIMIT
    // while a write is issued.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr       <= '0;
            pad_cnt    <= '0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            count_o    <= '0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            mem_we_o <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state   <= ST_LOAD;
                        addr    <= '0;
                        pad_cnt <= '0;
                        count_o <= '0;
                        done_o  <= 1'b0;
                        err_o   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (full_hit) begin
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end else if (accept) begin
                        if (illegal) begin
                            err_o <= 1'b1;
                        end else begin
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= addr;
                            mem_data_o <= packed_word;
                            addr       <= addr + 32'd4;
                            count_o    <= count_o + 16'd1;
                        end
                        if (last_i) begin
                            pad_cnt <= '0;
                            if (PAD_NOPS == 0) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end else begin
                                state <= ST_PAD;
                            end
                        end
                    end
                end
                ST_PAD: begin
                    if (pad_room) begin
                        mem_we_o   <= 1'b1;
                        mem_addr_o <= addr;
                        mem_data_o <= NOP_WORD;
                        addr       <= addr + 32'd4;
                        pad_cnt    <= pad_cnt + 16'd1;
                        if (pad_final) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end else begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter PAD_NOPS, default 4, number of NOP words appended after the last instruction.
REQ-003 clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  one-cycle pulse that begins a load session.
REQ-006 valid_i  in  1  instruction fields valid this cycle.
REQ-007 ready_o  out  1  encoder accepts a beat this cycle.
REQ-008 last_i  in  1  accompanies the final beat of a session.
REQ-009 kind_i  in  2  format: 00 R, 01 I, 10 J, 11 illegal.
REQ-010 op_i  in  6, rs_i  in  5, rt_i  in  5, rd_i  in  5, shamt_i  in  5, funct_i  in  6, imm_i  in  16, target_i  in  26  instruction fields.
REQ-011 mem_we_o  out  1  instruction-memory write strobe.
REQ-012 mem_addr_o  out  32  byte address of the write.
REQ-013 mem_data_o  out  32  encoded instruction word.
REQ-014 count_o  out  16  instruction words written this session, excluding pads.
REQ-015 done_o  out  1  session complete; held until the next start_i.
REQ-016 err_o  out  1  sticky error flag; cleared by start_i.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, PAD and DONE.
REQ-018 IDLE->LOAD on start_i; DONE->LOAD on start_i; start_i in LOAD or PAD SHALL be ignored.
REQ-019 On entry to LOAD, the write address SHALL be 0, count_o 0, done_o 0 and err_o 0.
REQ-020 ready_o SHALL be 1 only in LOAD while the address is below DEPTH*4.
REQ-021 A beat SHALL be accepted when valid_i && ready_o; exactly one word SHALL be written per accepted legal beat.
REQ-022 Encoding: R = {6'b0, rs, rt, rd, shamt, funct}, with op_i ignored; I = {op, rs, rt, imm}; J = {op, target}.
REQ-023 The write SHALL be registered: mem_we_o, mem_addr_o and mem_data_o SHALL be valid the cycle after acceptance, with mem_we_o high for one cycle.
REQ-024 After each write, the address SHALL advance by 4 and count_o SHALL increment by 1.
REQ-025 A beat with kind 11 SHALL set err_o and produce no write and no address advance; a kind-11 beat carrying last_i SHALL still end LOAD.
REQ-026 An accepted beat with last_i SHALL move the FSM LOAD->PAD.
REQ-027 PAD SHALL write PAD_NOPS words of 32'h0, one per cycle, at consecutive addresses, without incrementing count_o; it SHALL stop early when the address reaches DEPTH*4.
REQ-028 PAD->DONE SHALL occur after the last pad write; done_o SHALL rise in the cycle DONE is entered.
REQ-029 Full condition: an attempted beat (valid_i=1) in LOAD with the address at DEPTH*4 SHALL set err_o and move the FSM to DONE without writing.
REQ-030 mem_addr_o SHALL never be driven with a value of DEPTH*4 or above while mem_we_o=1.
REQ-031 With PAD_NOPS=0, LOAD SHALL go directly to DONE.

Reset
REQ-032 When rst_n=0, the FSM SHALL go to IDLE immediately; mem_we_o, ready_o, done_o and err_o SHALL be 0; mem_addr_o, mem_data_o and count_o SHALL be 0.
REQ-033 Reset during LOAD or PAD SHALL abort the session with no further writes after rst_n deasserts until a new start_i.

Structure
REQ-034 A shared package SHALL hold the kind codes, the FSM state encoding and the NOP constant 32'h0.
REQ-035 Field packing SHALL live in one combinational sub-module, instr_pack, that maps kind and fields to a 32-bit word and an illegal flag.

Verification
REQ-036 Scenario: start; R beat rs=1, rt=2, rd=3, shamt=0, funct=32, last -> write addr 0, data 0x00221820; then 4 NOPs at 4..16; count_o=1; done_o=1.
REQ-037 Scenario: I beat op=8, rs=0, rt=5, imm=0x000A, then J beat op=2, target=0x0000010 with last -> data 0x2005000A at 0, 0x08000010 at 4; count_o=2.
REQ-038 Scenario: kind 11 beat between two legal beats -> err_o=1; legal words at 0 and 4 with no gap.
REQ-039 Scenario: DEPTH=4, PAD_NOPS=4, 5 beats -> 4 writes at 0..12; err_o=1; done_o=1; no write at 16.
REQ-040 Scenario: rst_n low for one cycle mid-PAD -> outputs 0 immediately; no writes until start_i; the next session starts at addr 0.
REQ-041 Scenario: valid_i held with gaps and start_i pulsed during LOAD -> start ignored; only handshaked beats are written, in order.
